// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first a-b-bin subtractor (start/busy/done handshake, optional clamp-to-zero via sat; outputs diff/borrow/zero)
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] ra, rb, acc, nd;
  logic [CW-1:0] cnt;
  logic br, rsat, d, bo;
  always_comb begin
    d = ra[0] ^ rb[0] ^ br;
    bo = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    nd = (rsat & bo) ? '0 : {d, acc[WIDTH-1:1]};
  end
  assign busy = state == SHIFT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      cnt <= '0;
      br <= 1'b0;
      rsat <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
      zero <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ra <= a;
          rb <= b;
          br <= bin;
          rsat <= sat;
          cnt <= '0;
          state <= SHIFT;
        end
      end else begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        acc <= {d, acc[WIDTH-1:1]};
        br <= bo;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          diff <= nd;
          borrow <= bo;
          zero <= nd == '0;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=13
module tb_serial_sub;
  typedef struct {logic [31:0] d; logic bo; logic z; int c;} exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, cyc = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [31:0] opa[2], opb[2];
  logic st[2], bi[2], sa[2];
  logic bsy[2], dn[2], bor[2], zr[2];
  logic [7:0] diff8;
  logic [12:0] diff13;

  serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st[0]), .a(opa[0][7:0]), .b(opb[0][7:0]),
    .bin(bi[0]), .sat(sa[0]), .busy(bsy[0]), .done(dn[0]), .diff(diff8), .borrow(bor[0]), .zero(zr[0]));
  serial_sub #(.WIDTH(13)) u13 (.clk(clk), .rst(rst), .start(st[1]), .a(opa[1][12:0]), .b(opb[1][12:0]),
    .bin(bi[1]), .sat(sa[1]), .busy(bsy[1]), .done(dn[1]), .diff(diff13), .borrow(bor[1]), .zero(zr[1]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wl(int l);
    return l != 0 ? 13 : 8;
  endfunction

  function automatic logic [31:0] dv(int l);
    return l != 0 ? 32'(diff13) : 32'(diff8);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", n, act, want);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic exp_t model(int l, logic [31:0] a, logic [31:0] b, logic bin, logic sat);
    exp_t e;
    longint m = longint'(1) << wl(l);
    longint r = longint'(a) - longint'(b) - longint'(bin);
    e.bo = r < 0;
    e.d = 32'(((r % m) + m) % m);
    if (sat && e.bo) e.d = 0;
    e.z = e.d == 0;
    e.c = 0;
    return e;
  endfunction

  task automatic cmp(int l, exp_t e);
    chk($sformatf("diff w%0d", wl(l)), dv(l), e.d);
    chk($sformatf("borrow w%0d", wl(l)), 32'(bor[l]), 32'(e.bo));
    chk($sformatf("zero w%0d", wl(l)), 32'(zr[l]), 32'(e.z));
    chk($sformatf("latency w%0d", wl(l)), cyc, e.c);
  endtask

  always @(negedge clk) if (dn[0] === 1'b1) begin
    if (q0.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL unexpected done w8");
    end else begin
      e0 = q0.pop_front();
      cmp(0, e0);
    end
  end

  always @(negedge clk) if (dn[1] === 1'b1) begin
    if (q1.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL unexpected done w13");
    end else begin
      e1 = q1.pop_front();
      cmp(1, e1);
    end
  end

  task automatic issue(int l, logic [31:0] a, logic [31:0] b, logic bin, logic sat);
    logic [31:0] m = (32'd1 << wl(l)) - 1;
    exp_t e = model(l, a & m, b & m, bin, sat);
    opa[l] = a & m;
    opb[l] = b & m;
    bi[l] = bin;
    sa[l] = sat;
    st[l] = 1;
    @(posedge clk);
    #1;
    e.c = cyc + wl(l);
    if (l != 0) q1.push_back(e); else q0.push_back(e);
  endtask

  // Runs one operation; with hold=1, start stays high and inputs churn while busy.
  task automatic op(int l, logic [31:0] a, logic [31:0] b, logic bin, logic sat, bit hold = 0);
    int bc = 0;
    int i;
    issue(l, a, b, bin, sat);
    if (!hold) st[l] = 0;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dn[l]) break;
      if (bsy[l]) bc++;
      if (hold) begin
        opa[l] = $urandom;
        opb[l] = $urandom;
        bi[l] = 1'($urandom);
        sa[l] = 1'($urandom);
      end
    end
    st[l] = 0;
    if (i == 60) begin
      vecs++;
      errs++;
      $display("FAIL timeout waiting for done w%0d", wl(l));
    end
    chk($sformatf("busy cycles w%0d", wl(l)), bc, wl(l));
  endtask

  task automatic chk_reset(int l);
    chk($sformatf("rst diff w%0d", wl(l)), dv(l), 0);
    chk($sformatf("rst borrow w%0d", wl(l)), 32'(bor[l]), 0);
    chk($sformatf("rst zero w%0d", wl(l)), 32'(zr[l]), 1);
    chk($sformatf("rst busy w%0d", wl(l)), 32'(bsy[l]), 0);
    chk($sformatf("rst done w%0d", wl(l)), 32'(dn[l]), 0);
  endtask

  initial begin
    int dc;
    for (int l = 0; l < 2; l++) begin
      opa[l] = 0;
      opb[l] = 0;
      st[l] = 0;
      bi[l] = 0;
      sa[l] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 0;
    @(negedge clk);
    op(0, 100, 37, 0, 0);
    op(0, 5, 9, 0, 0);
    op(0, 5, 9, 0, 1);
    op(0, 8'hFF, 8'hFF, 1, 0);
    op(0, 0, 0, 0, 0);
    op(0, 8'hC8, 8'h11, 0, 0, 1);
    op(0, 77, 12, 1, 1);
    @(negedge clk);
    issue(0, 200, 3, 0, 0);
    st[0] = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1 chk_reset(0);
    q0.delete();
    @(posedge clk);
    #1 rst = 0;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0]) dc++;
    end
    chk("done after reset", dc, 0);
    op(0, 200, 150, 0, 0);
    for (int l = 0; l < 2; l++)
      for (int n = 0; n < 200; n++)
        op(l, $urandom, $urandom, 1'($urandom), $urandom_range(3) == 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained w8", q0.size(), 0);
    chk("scoreboard drained w13", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
